mimc_round_ctrl: RTL
====================

// Module: mimc_round_ctrl
// PURPOSE
// - MiMC-5 round sequencer for BN254; sits directly upstream of galois_pow_5 and drives it round by round.
// - Per round: computes t = (state + key + rc[i]) mod PRIME, hands t to the pow-5 stage, and captures t^5 as the new state.
// - After N_ROUNDS rounds it outputs hash = (state + key) mod PRIME.
// PARAMETERS
// - N_BITS    254     field element width
// - N_ROUNDS  110     number of MiMC rounds (ceil(254/log2 5))
// - PRIME     0x30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001  field modulus, N_BITS wide
// PORTS
// - clk         in   1       single clock, rising edge
// - rst         in   1       reset, asynchronous, active-high
// - en          in   1       start/hold; level-sensitive, same convention as galois_pow_5
// - msg         in   N_BITS  message element, sampled in IDLE when en=1
// - key         in   N_BITS  key element, sampled together with msg
// - rc_addr     out  $clog2(N_ROUNDS)  round-constant ROM address (= round index)
// - rc_data     in   N_BITS  round constant; combinational ROM, valid in the same cycle as rc_addr
// - pow_rst     out  1       to galois_pow_5 rst
// - pow_en      out  1       to galois_pow_5 en
// - pow_base    out  N_BITS  to galois_pow_5 base (registered)
// - pow_result  in   N_BITS  from galois_pow_5 result
// - pow_done    in   1       from galois_pow_5 done
// - hash        out  N_BITS  final hash, valid while done=1
// - done        out  1       completion flag
// BEHAVIOUR
// - Async reset: state=IDLE; round=0; hash=0; done=0; pow_en=0; pow_rst=1; pow_base=0; rc_addr=0.
// - States:
//   - IDLE
//     - pow_rst=1, pow_en=0.
//     - If en=1: latch msg into the state register and key into the key register, round=0, go to ADD.
//   - ADD (1 cycle)
//     - pow_base <= modadd(modadd(state, key), rc_data) with rc_addr=round.
//     - Go to PRST.
//   - PRST (1 cycle)
//     - pow_rst=1, pow_en=0; clears the previous done in the pow stage.
//     - Go to PRUN.
//   - PRUN
//     - pow_rst=0, pow_en=1, pow_base held stable.
//     - On the cycle pow_done=1: state <= pow_result, round <= round+1.
//     - If round == N_ROUNDS-1 go to FINAL, else go to ADD.
//   - FINAL (1 cycle)
//     - hash <= modadd(state, key).
//     - Go to DONE.
//   - DONE
//     - done=1, hash held, pow_rst=1.
//     - When en=0: done=0, go to IDLE.
// - modadd(a,b) for a,b < PRIME:
//   - s = a + b computed at N_BITS+1 bits.
//   - Result is s - PRIME if s >= PRIME, else s; result is always < PRIME.
// - Latency: with Lp = PRUN cycles per round (pow_done sampled inclusive), done rises 2 + N_ROUNDS*(2+Lp) cycles after en is sampled high in IDLE.
// - en dropped in any state other than IDLE or DONE: abort to IDLE next cycle with done=0, pow_rst=1; hash keeps its old value.
// - Async rst mid-operation: immediate return to the reset values above; no partial result is exposed.
// - A pow_done that is already high when PRUN is entered cannot occur, because PRST clears it; pow_done in any other state is ignored.
// - Round counter never wraps: it terminates at N_ROUNDS.
// - N_ROUNDS=1 is legal: ADD, PRST, PRUN, FINAL.
// CONFIGURATION
// - MIMC_INPUT_REDUCE_EN
//   - Defined: msg and key are each reduced once on capture (x >= PRIME -> x - PRIME). Inputs in [PRIME, 2^N_BITS) become legal only if 2*PRIME > 2^N_BITS.
//   - Undefined: msg and key must already be < PRIME. Results for larger values are unspecified; no reduction logic is built.
// TESTING (bench uses a behavioural pow-5 model mod PRIME with Lp=3 unless stated)
// - Test 1: N_BITS=8, PRIME=251, N_ROUNDS=2, rc={5,7}, msg=2, key=3 -> hash=19; done at cycle 2+2*5=12 after en.
// - Test 2: PRIME=251, N_ROUNDS=1, rc={250}, msg=250, key=250 -> modadd wrap gives t=248, 248^5=8, hash=7.
// - Test 3: default BN254 params, msg=0, key=0, all rc=0 -> hash=0; done held until en=0, then done=0 next cycle.
// - Test 4: PRIME=251, en dropped in round 1 PRUN -> IDLE next cycle, done never rises; re-run with Test 1 inputs -> hash=19.
// - Test 5: rst asserted asynchronously mid-PRUN -> all outputs at reset values before the next clk edge; pow_rst=1.
// - Test 6: MIMC_INPUT_REDUCE_EN, N_BITS=8, PRIME=251, msg=255 (captured as 4), key=0, N_ROUNDS=1, rc={0} -> hash = 4^5 mod 251 = 20.

Source files
------------

// File: rtl/mimc_round_ctrl.sv
// MiMC-5 round sequencer: drives an external pow-5 stage round by round and forms the final hash.
// Optional capture-time reduction of msg/key is enabled by defining MIMC_INPUT_REDUCE_EN.
module mimc_round_ctrl #(
    parameter int unsigned N_BITS   = 254,
    parameter int unsigned N_ROUNDS = 110,
    parameter logic [N_BITS-1:0] PRIME =
        N_BITS'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001),
    localparam int unsigned ADDR_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] msg,
    input  logic [N_BITS-1:0] key,
    output logic [ADDR_W-1:0] rc_addr,
    input  logic [N_BITS-1:0] rc_data,
    output logic              pow_rst,
    output logic              pow_en,
    output logic [N_BITS-1:0] pow_base,
    input  logic [N_BITS-1:0] pow_result,
    input  logic              pow_done,
    output logic [N_BITS-1:0] hash,
    output logic              done
);

    // Round counter is one count wider than the ROM address so it can rest at N_ROUNDS.
    localparam int unsigned      RND_W    = $clog2(N_ROUNDS + 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(N_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_PRST,
        S_PRUN,
        S_FINAL,
        S_DONE
    } fsm_t;

    fsm_t              fsm;
    fsm_t              next_fsm;
    logic [RND_W-1:0]  round;
    logic [N_BITS-1:0] acc;
    logic [N_BITS-1:0] key_q;
    logic [N_BITS-1:0] msg_in;
    logic [N_BITS-1:0] key_in;

    // Field addition for operands already below PRIME, with one carry bit of headroom.
    function automatic logic [N_BITS-1:0] modadd(input logic [N_BITS-1:0] a,
                                                 input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        return s[N_BITS-1:0];
    endfunction

`ifdef MIMC_INPUT_REDUCE_EN
    function automatic logic [N_BITS-1:0] reduce(input logic [N_BITS-1:0] x);
        return (x >= PRIME) ? x - PRIME : x;
    endfunction

    assign msg_in = reduce(msg);
    assign key_in = reduce(key);
`else
    assign msg_in = msg;
    assign key_in = key;
`endif

    assign rc_addr = ADDR_W'(round);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= S_IDLE;
        else     fsm <= next_fsm;
    end

    // Dropping en anywhere mid-computation aborts straight back to IDLE.
    always_comb begin
        next_fsm = fsm;
        case (fsm)
            S_IDLE:  if (en) next_fsm = S_ADD;
            S_ADD:   next_fsm = en ? S_PRST : S_IDLE;
            S_PRST:  next_fsm = en ? S_PRUN : S_IDLE;
            S_PRUN: begin
                if (!en)           next_fsm = S_IDLE;
                else if (pow_done) next_fsm = (round == LAST_RND) ? S_FINAL : S_ADD;
            end
            S_FINAL: next_fsm = en ? S_DONE : S_IDLE;
            S_DONE:  if (!en) next_fsm = S_IDLE;
            default: next_fsm = S_IDLE;
        endcase
    end

    // Pow-stage controls and done are decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round    <= '0;
            acc      <= '0;
            key_q    <= '0;
            pow_base <= '0;
            hash     <= '0;
            done     <= 1'b0;
            pow_en   <= 1'b0;
            pow_rst  <= 1'b1;
        end else begin
            pow_en  <= (next_fsm == S_PRUN);
            pow_rst <= (next_fsm != S_PRUN);
            done    <= (next_fsm == S_DONE);
            case (fsm)
                S_IDLE: begin
                    if (en) begin
                        acc   <= msg_in;
                        key_q <= key_in;
                        round <= '0;
                    end
                end
                S_ADD:   pow_base <= modadd(modadd(acc, key_q), rc_data);
                S_PRUN: begin
                    if (en && pow_done) begin
                        acc   <= pow_result;
                        round <= round + RND_W'(1);
                    end
                end
                S_FINAL: if (en) hash <= modadd(acc, key_q);
                default: ;
            endcase
        end
    end

endmodule
